fetch_ctrl: RTL
===============

Name: fetch_ctrl

Overview:
Instruction-fetch sequencer for the 64-bit RISC-V core. Owns the fetch PC and drives the address of the combinational 256-word instruction memory. Buffers fetched words in a small prefetch FIFO and hands them to decode over a valid/ready handshake. Handles control-flow redirects (JAL/JALR/branch) with a flush, and enters a fault state on misaligned or out-of-range fetch addresses.

Parameters:
RESET_PC, 64'h0, fetch PC loaded on reset
DEPTH, 2, prefetch FIFO entries (power of 2, min 2)
MEM_WORDS, 256, instruction memory size in 32-bit words; valid byte range is 0 .. MEM_WORDS*4-1

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
imem_addr  out  64  byte address to instruction memory; combinational copy of fetch_pc
imem_instr  in  32  instruction word read combinationally at imem_addr
redirect_valid  in  1  one-cycle pulse: flush and restart fetch at redirect_pc
redirect_pc  in  64  redirect target byte address
out_valid  out  1  FIFO head holds a valid instruction
out_ready  in  1  decode accepts the head this cycle
out_instr  out  32  head instruction word
out_pc  out  64  byte address of the head instruction
fault  out  1  fetch halted on a bad address
fault_pc  out  64  offending address, latched on fault entry

Behaviour:
- Reset (rst high at a rising edge): fetch_pc=RESET_PC, FIFO empty, state=RUN, fault=0, fault_pc=0. out_valid=0; out_instr and out_pc are 0 whenever out_valid=0.
- States: RUN, FAULT.
- RUN, no redirect:
  - pop = out_valid & out_ready.
  - push = (FIFO not full) | pop. Pushing into a full FIFO while popping in the same cycle is allowed.
  - On push: write {fetch_pc, imem_instr} at the tail, then fetch_pc += 4.
  - Count updates as count + push - pop.
- Latency: the first instruction is valid one cycle after the first edge at which rst is low. At steady state with out_ready=1, one instruction is delivered per cycle.
- Ordering: out_pc advances by 4 per accepted instruction, with no duplicates and no gaps.
- Redirect (redirect_valid=1, any state):
  - If out_valid & out_ready, the pop completes that cycle.
  - All FIFO entries are flushed and no push happens that cycle.
  - fetch_pc <= redirect_pc.
  - out_valid=0 for the cycle after the redirect edge. The target instruction appears with out_valid=1 one cycle later, at out_pc=redirect_pc.
  - Redirect takes priority over the normal push.
- Misaligned redirect (redirect_pc[1:0] != 0): flush, state -> FAULT, fault_pc=redirect_pc, fault=1 from the next cycle.
- Out-of-range fetch (RUN and fetch_pc >= MEM_WORDS*4, with no redirect this cycle):
  - No push.
  - state -> FAULT, fault_pc=fetch_pc.
  - Entries already in the FIFO still drain normally to decode.
- FAULT:
  - No pushes; imem_addr holds fetch_pc.
  - FIFO keeps draining.
  - fault stays high until an aligned, in-range redirect or reset.
  - An aligned, in-range redirect returns to RUN, clears fault, keeps fault_pc, and follows normal redirect timing.
  - A bad redirect while in FAULT updates fault_pc.
- Address arithmetic: 64-bit, wraps modulo 2^64. The wrap is unreachable in practice because the range check faults first.
- out_ready while out_valid=0 has no effect.
- Reset mid-operation: overrides redirect and handshake in the same cycle; FIFO contents are discarded.
- All state is in registers. imem_addr, out_valid, out_instr and out_pc are driven from registers, with no combinational path from inputs to outputs.

Test Plan:
- Reset release, RESET_PC=0, mem[0]=32'h00808567, mem[1..]=NOP 32'h00000013, out_ready=1 -> cycle 1: out_pc=0, out_instr=00808567; cycle 2: out_pc=4, out_instr=00000013; then +4 per cycle.
- out_ready=0 for 5 cycles after reset -> FIFO fills to DEPTH=2 and imem_addr stalls at 8. Raise out_ready -> pcs 0,4,8,12 delivered back-to-back with no loss.
- Redirect to 72 while the head is pc=4 with out_ready=1 -> pc=4 is accepted, the next cycle has out_valid=0, then out_pc=72 with instr 00000013, then 76.
- Redirect to 70 (misaligned) -> fault=1 and fault_pc=70 next cycle, out_valid stays 0. Then redirect to 8 -> fault=0, out_pc=8 two cycles later.
- Sequential fetch to 1020 with MEM_WORDS=256 -> pc 1020 delivered, then fault=1 with fault_pc=1024 and no further valid output.
- Assert rst mid-stream with out_valid=1 and redirect_valid=1 in the same cycle -> next cycle: out_valid=0, fault=0, imem_addr=RESET_PC. Normal fetch resumes from 0.

Source files
------------

// File: rtl/fetch_ctrl_if.sv
// Fetch sequencer bus: instruction-memory port, redirect request, decode handshake and fault status.
// The fetch side uses the master modport and the environment uses the slave modport.
interface fetch_ctrl_if;
   logic [63:0] imem_addr;
   logic [31:0] imem_instr;
   logic        redirect_valid;
   logic [63:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [63:0] out_pc;
   logic        fault;
   logic [63:0] fault_pc;

   modport master (
      output imem_addr,
      input  imem_instr,
      input  redirect_valid,
      input  redirect_pc,
      output out_valid,
      input  out_ready,
      output out_instr,
      output out_pc,
      output fault,
      output fault_pc
   );

   modport slave (
      input  imem_addr,
      output imem_instr,
      output redirect_valid,
      output redirect_pc,
      input  out_valid,
      output out_ready,
      input  out_instr,
      input  out_pc,
      input  fault,
      input  fault_pc
   );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, buffers {pc, instr} pairs in a small
// prefetch FIFO for decode, flushes on redirect and halts on misaligned or out-of-range fetches.
module fetch_ctrl #(
   parameter logic [63:0] RESET_PC  = 64'h0,
   parameter int          DEPTH     = 2,
   parameter int          MEM_WORDS = 256
) (
   input  logic         clk,
   input  logic         rst,
   fetch_ctrl_if.master bus
);
   localparam int          PTR_W     = $clog2(DEPTH);
   localparam logic [63:0] MEM_BYTES = 64'(MEM_WORDS) * 64'd4;

   typedef enum logic {ST_RUN = 1'b0, ST_FAULT = 1'b1} state_t;

   state_t            state_q, state_d;
   logic [63:0]       fetch_pc_q, fetch_pc_d;
   logic [63:0]       fault_pc_q, fault_pc_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W:0]    count_q, count_d;
   logic [63:0]       pc_mem_q    [DEPTH];
   logic [31:0]       instr_mem_q [DEPTH];

   logic head_valid;
   logic fifo_full;
   logic pop;
   logic push;
   logic redirect_mis;
   logic redirect_oor;
   logic redirect_to_fault;
   logic fetch_oor;

   always_comb begin
      head_valid   = (count_q != '0);
      fifo_full    = (count_q == (PTR_W+1)'(DEPTH));
      pop          = head_valid & bus.out_ready;
      redirect_mis = (bus.redirect_pc[1:0] != 2'b00);
      redirect_oor = (bus.redirect_pc >= MEM_BYTES);
      // An aligned out-of-range target only faults immediately if already halted;
      // from RUN it is caught one cycle later by the normal range check.
      redirect_to_fault = redirect_mis | ((state_q == ST_FAULT) & redirect_oor);
      fetch_oor    = (fetch_pc_q >= MEM_BYTES);
      push         = (state_q == ST_RUN) & ~bus.redirect_valid & ~fetch_oor
                     & (~fifo_full | pop);
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_RUN;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      if (bus.redirect_valid) begin
         state_d = redirect_to_fault ? ST_FAULT : ST_RUN;
      end else if ((state_q == ST_RUN) && fetch_oor) begin
         state_d = ST_FAULT;
      end
   end

   // Output logic
   always_comb begin
      bus.imem_addr = fetch_pc_q;
      bus.out_valid = head_valid;
      bus.out_instr = head_valid ? instr_mem_q[rd_ptr_q] : 32'h0;
      bus.out_pc    = head_valid ? pc_mem_q[rd_ptr_q] : 64'h0;
      bus.fault     = (state_q == ST_FAULT);
      bus.fault_pc  = fault_pc_q;
   end

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      fault_pc_d = fault_pc_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q;
      if (bus.redirect_valid) begin
         fetch_pc_d = bus.redirect_pc;
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         count_d    = '0;
         if (redirect_to_fault) begin
            fault_pc_d = bus.redirect_pc;
         end
      end else begin
         if ((state_q == ST_RUN) && fetch_oor) begin
            fault_pc_d = fetch_pc_q;
         end
         if (push) begin
            fetch_pc_d = fetch_pc_q + 64'd4;
            wr_ptr_d   = wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         count_d = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc_q <= RESET_PC;
         fault_pc_q <= 64'h0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         fault_pc_q <= fault_pc_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
      end
   end

   // Entry storage needs no reset: occupancy is tracked solely by count_q.
   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem_q[wr_ptr_q]    <= fetch_pc_q;
         instr_mem_q[wr_ptr_q] <= bus.imem_instr;
      end
   end
endmodule
